lpimo_copy_engine: RTL and testbench

LPIMO_COPY_ENGINE -- requirements
Module: lpimo_copy_engine

---
 rtl/lpimo_copy_pkg.sv | 21 ++
 rtl/lpimo_copy_engine_if.sv | 26 ++
 rtl/lpimo_copy_fifo.sv | 48 ++++
 rtl/lpimo_copy_engine.sv | 165 ++++++++++++++++
 tb/tb_lpimo_copy_engine.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lpimo_copy_pkg.sv
// Shared encodings for the copy engine: FSM states and the request-type tag
// carried through the in-order response tracking queue.
package lpimo_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } copy_state_t;

  typedef enum logic {
    TAG_READ  = 1'b0,
    TAG_WRITE = 1'b1
  } copy_tag_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lpimo_copy_engine_if.sv
// Request/response bus between the copy engine and the memory system.
interface lpimo_copy_engine_if #(
  parameter int BW_ADDR = 32,
  parameter int BW_DATA = 32
);
  // Both channels use valid/ready: a beat moves on a clock edge where valid and
  // ready are both high; the sender holds valid and payload until that edge.
  logic               sqvalid;
  logic               sqready;
  logic               sqwrite;
  logic [BW_ADDR-1:0] sqaddr;
  logic [BW_DATA-1:0] sqwdata;
  logic               syvalid;
  logic               syready;
  logic [BW_DATA-1:0] sydata;

  modport master (
    output sqvalid, sqwrite, sqaddr, sqwdata, syready,
    input  sqready, syvalid, sydata
  );

  modport slave (
    input  sqvalid, sqwrite, sqaddr, sqwdata, syready,
    output sqready, syvalid, sydata
  );
endinterface

// File: rtl/lpimo_copy_fifo.sv
// Registered FIFO with simultaneous push/pop; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module lpimo_copy_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;
endmodule

// File: rtl/lpimo_copy_engine.sv
// Word copy engine: streams reads from src into a small buffer and writes them
// to dst, with read credits bounded by buffer space and in-order response tags.
module lpimo_copy_engine
  import lpimo_copy_pkg::*;
#(
  parameter int BW_ADDR   = 32,
  parameter int BW_DATA   = 32,
  parameter int BW_LEN    = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                start,
  input  logic [BW_ADDR-1:0]  src_addr,
  input  logic [BW_ADDR-1:0]  dst_addr,
  input  logic [BW_LEN-1:0]   num_words,
  output logic                busy,
  output logic                done,
  output copy_state_t         state_dbg,
  lpimo_copy_engine_if.master bus
);
  localparam int BUF_CW    = cnt_width(BUF_DEPTH);
  localparam int TAG_DEPTH = 2 * BUF_DEPTH;
  localparam int TAG_CW    = cnt_width(TAG_DEPTH);
  localparam logic [BW_ADDR-1:0] STEP = BW_ADDR'(BW_DATA / 8);

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BUF_DEPTH must be a power of 2 and at least 2");
  end

  copy_state_t        state;
  logic [BW_ADDR-1:0] src_ptr;
  logic [BW_ADDR-1:0] dst_ptr;
  logic [BW_LEN-1:0]  rd_left;
  logic [BW_LEN-1:0]  wr_left;
  logic [BW_LEN-1:0]  num_r;
  logic [BW_LEN-1:0]  ack_cnt;
  logic [BUF_CW-1:0]  rd_pend;

  logic               tag_push;
  logic               tag_pop;
  logic [0:0]         tag_dout;
  logic               tag_empty;
  logic [TAG_CW-1:0]  tag_count;
  logic               buf_push;
  logic               buf_pop;
  logic [BW_DATA-1:0] buf_dout;
  logic               buf_empty;
  logic [BUF_CW-1:0]  buf_count;

  logic slot_free;
  logic tag_room;
  logic sel_write;
  logic sel_read;

  assign tag_push = bus.sqvalid && bus.sqready;
  assign tag_pop  = bus.syvalid && bus.syready && !tag_empty;
  assign buf_push = tag_pop && (copy_tag_t'(tag_dout) == TAG_READ);
  assign buf_pop  = sel_write;

  // A new request may be chosen when the output slot is empty or drains this
  // cycle, and the tag queue is guaranteed room for it even with no response.
  assign slot_free = !bus.sqvalid || bus.sqready;
  assign tag_room  = (tag_count + TAG_CW'(tag_push)) < TAG_CW'(TAG_DEPTH);
  assign sel_write = (state == RUN) && slot_free && tag_room && !buf_empty;
  assign sel_read  = (state == RUN) && slot_free && tag_room && buf_empty &&
                     (rd_left != '0) &&
                     ((rd_pend + buf_count) < BUF_CW'(BUF_DEPTH));

  lpimo_copy_fifo #(.WIDTH(1), .DEPTH(TAG_DEPTH)) u_tag_q (
    .clk   (clk),
    .rstnn (rstnn),
    .push  (tag_push),
    .din   (bus.sqwrite),
    .pop   (tag_pop),
    .dout  (tag_dout),
    .empty (tag_empty),
    .count (tag_count)
  );

  lpimo_copy_fifo #(.WIDTH(BW_DATA), .DEPTH(BUF_DEPTH)) u_data_buf (
    .clk   (clk),
    .rstnn (rstnn),
    .push  (buf_push),
    .din   (bus.sydata),
    .pop   (buf_pop),
    .dout  (buf_dout),
    .empty (buf_empty),
    .count (buf_count)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      rd_left     <= '0;
      wr_left     <= '0;
      num_r       <= '0;
      ack_cnt     <= '0;
      rd_pend     <= '0;
      bus.sqvalid <= 1'b0;
      bus.sqwrite <= 1'b0;
      bus.sqaddr  <= '0;
      bus.sqwdata <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= rd_pend + BUF_CW'(sel_read) - BUF_CW'(buf_push);
      if (tag_pop && (copy_tag_t'(tag_dout) == TAG_WRITE)) ack_cnt <= ack_cnt + BW_LEN'(1);

      if (sel_write) begin
        bus.sqvalid <= 1'b1;
        bus.sqwrite <= TAG_WRITE;
        bus.sqaddr  <= dst_ptr;
        bus.sqwdata <= buf_dout;
        dst_ptr     <= dst_ptr + STEP;
        wr_left     <= wr_left - BW_LEN'(1);
      end else if (sel_read) begin
        bus.sqvalid <= 1'b1;
        bus.sqwrite <= TAG_READ;
        bus.sqaddr  <= src_ptr;
        bus.sqwdata <= '0;
        src_ptr     <= src_ptr + STEP;
        rd_left     <= rd_left - BW_LEN'(1);
      end else if (tag_push) begin
        bus.sqvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            rd_left <= num_words;
            wr_left <= num_words;
            num_r   <= num_words;
            ack_cnt <= '0;
            if (num_words == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if ((wr_left == '0) && !bus.sqvalid) state <= FLUSH;
        end
        FLUSH: begin
          if (ack_cnt == num_r) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.syready = busy;
  assign state_dbg   = state;
endmodule

// File: tb/tb_lpimo_copy_engine.sv
// Directed bench for lpimo_copy_engine: table of copy jobs against a memory
// model with configurable response latency and request back-pressure.
module tb_lpimo_copy_engine;
  import lpimo_copy_pkg::*;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          num;
    int          lat;
    int          stall;
    int          poke;
    int          exp_reqs;
    int          max_rbw;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy;
  logic        done;
  copy_state_t state_dbg;

  lpimo_copy_engine_if #(.BW_ADDR(32), .BW_DATA(32)) bus ();

  lpimo_copy_engine #(.BW_ADDR(32), .BW_DATA(32), .BW_LEN(16), .BUF_DEPTH(4)) dut (
    .clk       (clk),
    .rstnn     (rstnn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_rd_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem [logic [31:0]];
  int cyc = 0;
  int lat = 1;
  int stall_pct = 0;
  int req_cnt, rd_cnt, wr_cnt, done_cnt, rbw, max_out;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_payload = '0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model: drives sqready/syvalid and checks every accepted request
  always @(negedge clk) begin
    cyc++;
    if (!rstnn) begin
      bus.syvalid = 1'b0;
      bus.sydata  = '0;
      bus.sqready = 1'b1;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", bus.sqvalid, 1'b1);
        chk("stall_payload_held", {bus.sqwrite, bus.sqaddr, bus.sqwdata}, prev_payload);
      end
      bus.sqready  = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      prev_stall   = bus.sqvalid && !bus.sqready;
      prev_payload = {bus.sqwrite, bus.sqaddr, bus.sqwdata};
      if (bus.sqvalid && bus.sqready) begin
        req_cnt++;
        if (bus.sqwrite) begin
          wr_cnt++;
          if (exp_q.size() == 0) chk("unexpected_write", {bus.sqaddr, bus.sqwdata}, 64'h0);
          else chk("write_addr_data", {bus.sqaddr, bus.sqwdata}, exp_q.pop_front());
          mem[bus.sqaddr] = bus.sqwdata;
          rsp_q.push_back('{cyc + lat, 32'h0});
        end else begin
          rd_cnt++;
          if (wr_cnt == 0) rbw++;
          if (exp_rd_q.size() == 0) chk("unexpected_read", bus.sqaddr, 32'h0);
          else chk("read_addr", bus.sqaddr, exp_rd_q.pop_front());
          rsp_q.push_back('{cyc + lat, mem.exists(bus.sqaddr) ? mem[bus.sqaddr] : 32'hBAD0_0000});
        end
        if (rsp_q.size() > max_out) max_out = rsp_q.size();
      end
      if (done) done_cnt++;
      bus.syvalid = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
      bus.sydata  = bus.syvalid ? rsp_q[0].data : 32'h0;
      if (bus.syvalid && bus.syready) void'(rsp_q.pop_front());
    end
  end

  // driver tasks
  task automatic launch(input vec_t v);
    logic [31:0] a, wa, d;
    stall_pct = v.stall;
    lat       = v.lat;
    req_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; rbw = 0; max_out = 0;
    for (int i = 0; i < v.num; i++) begin
      a  = v.src + 32'(4 * i);
      wa = v.dst + 32'(4 * i);
      d  = $urandom;
      mem[a] = d;
      exp_rd_q.push_back(a);
      exp_q.push_back({wa, d});
    end
    @(negedge clk);
    src_addr  = v.src;
    dst_addr  = v.dst;
    num_words = 16'(v.num);
    start     = 1'b1;
  endtask

  task automatic finish_copy(input vec_t v);
    logic got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      start = (v.poke != 0) && (c == v.poke);
      if (start) begin
        src_addr  = 32'hDEAD_0000;
        dst_addr  = 32'hBEEF_0000;
        num_words = 16'd3;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", got, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after", busy, 1'b0);
    chk("state_after", state_dbg, IDLE);
    chk("request_count", req_cnt, v.exp_reqs);
    chk("read_count", rd_cnt, v.num);
    chk("write_count", wr_cnt, v.num);
    chk("writes_left", exp_q.size(), 0);
    chk("reads_before_write_bound", rbw <= v.max_rbw, 1'b1);
    chk("outstanding_bound", max_out <= 8, 1'b1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 1,  1,  0,  0, 2,  1};
    vecs[1] = '{32'h0000_1000, 32'h0000_2000, 8,  5,  0,  0, 16, 4};
    vecs[2] = '{32'h0000_3000, 32'h0000_3800, 6,  2,  40, 0, 12, 4};
    vecs[3] = '{32'h0000_0500, 32'h0000_0600, 5,  3,  0,  6, 10, 4};
    vecs[4] = '{32'hFFFF_FFF8, 32'h0000_0040, 4,  1,  0,  0, 8,  4};
    vecs[5] = '{32'h0000_4000, 32'h0000_5000, 12, 20, 20, 0, 24, 4};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sqvalid", bus.sqvalid, 1'b0);
    chk("rst_sqwrite", bus.sqwrite, 1'b0);
    chk("rst_sqaddr", bus.sqaddr, 32'h0);
    chk("rst_sqwdata", bus.sqwdata, 32'h0);
    chk("rst_syready", bus.syready, 1'b0);
    chk("rst_state", state_dbg, IDLE);
    rstnn = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      launch(vecs[k]);
      finish_copy(vecs[k]);
    end

    // zero-length copy: done on the next cycle, no requests
    req_cnt = 0; done_cnt = 0;
    @(negedge clk);
    src_addr = 32'h300; dst_addr = 32'h400; num_words = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_next", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    @(negedge clk);
    chk("zero_done_single", done, 1'b0);
    repeat (3) @(negedge clk);
    chk("zero_no_requests", req_cnt, 0);
    chk("zero_done_pulses", done_cnt, 1);

    // reset in the middle of a transfer
    begin
      vec_t r = '{32'h0000_6000, 32'h0000_7000, 8, 5, 0, 0, 16, 4};
      logic hit = 1'b0;
      launch(r);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (req_cnt >= 3) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("mid_third_request", hit, 1'b1);
      rstnn = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_sqvalid", bus.sqvalid, 1'b0);
      chk("mid_rst_sqwrite", bus.sqwrite, 1'b0);
      chk("mid_rst_sqaddr", bus.sqaddr, 32'h0);
      chk("mid_rst_sqwdata", bus.sqwdata, 32'h0);
      chk("mid_rst_syready", bus.syready, 1'b0);
      chk("mid_rst_state", state_dbg, IDLE);
      repeat (3) @(negedge clk);
      exp_q.delete();
      exp_rd_q.delete();
      rsp_q.delete();
      req_cnt = 0; done_cnt = 0;
      rstnn = 1'b1;
      rsp_q.push_back('{cyc, 32'h0BAD_0BAD});
      repeat (4) @(negedge clk);
      chk("stale_not_accepted", bus.syready, 1'b0);
      chk("stale_still_pending", rsp_q.size(), 1);
      rsp_q.delete();
      chk("post_rst_idle", state_dbg, IDLE);
      chk("post_rst_no_requests", req_cnt, 0);
      chk("post_rst_no_done", done_cnt, 0);
    end
    begin
      vec_t f = '{32'h0000_8000, 32'h0000_9000, 2, 1, 0, 0, 4, 2};
      launch(f);
      finish_copy(f);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
